// File: rtl/timer_pkg.sv
// Shared definitions for the microwave cook-timer sequencer: FSM encodings,
// BCD digit limits and the keypad digit filter.
package timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENTRY  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_RUN    = 3'd3,
        ST_PAUSE  = 3'd4,
        ST_FINISH = 3'd5
    } state_e;

    localparam logic [3:0] MAX_UNITS = 4'd9;
    localparam logic [3:0] MAX_TENS  = 4'd5;
    localparam logic [3:0] MAX_MIN   = 4'd9;

    // Keypad codes above this value are not digits and are dropped.
    localparam logic [3:0] KEY_MAX   = 4'd9;

    function automatic logic key_accepted(input logic [3:0] d);
        return d <= KEY_MAX;
    endfunction

    function automatic logic [3:0] sat_tens(input logic [3:0] d);
        return (d > MAX_TENS) ? MAX_TENS : d;
    endfunction

endpackage

// File: rtl/timer_entry_reg.sv
// M:ST entry register. Keys shift in from the right; a units digit above 5
// that moves into the seconds-tens slot saturates to 5.
module timer_entry_reg
    import timer_pkg::*;
#(
    parameter logic [3:0] QUICK_TENS = 4'd3
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       clr_i,
    input  logic       shift_i,
    input  logic [3:0] key_i,
    input  logic       quick_i,
    output logic [3:0] min_o,
    output logic [3:0] tens_o,
    output logic [3:0] units_o
);

    logic [3:0] min_q,   min_d;
    logic [3:0] tens_q,  tens_d;
    logic [3:0] units_q, units_d;

    always_comb begin
        min_d   = min_q;
        tens_d  = tens_q;
        units_d = units_q;
        if (clr_i) begin
            min_d   = 4'd0;
            tens_d  = 4'd0;
            units_d = 4'd0;
        end else if (shift_i) begin
            // Old minutes digit falls off the left end.
            min_d   = tens_q;
            tens_d  = sat_tens(units_q);
            units_d = (key_i > MAX_UNITS) ? units_q : key_i;
        end else if (quick_i) begin
            tens_d  = QUICK_TENS;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            min_q   <= 4'd0;
            tens_q  <= 4'd0;
            units_q <= 4'd0;
        end else begin
            min_q   <= min_d;
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    assign min_o   = min_q;
    assign tens_o  = tens_q;
    assign units_o = units_q;

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Cook-timer sequencer: keypad entry, counter load/enable/clear, 0:00
// detection, magnetron enable and end-of-cook beep. All outputs registered.
module microwave_timer_ctrl
    import timer_pkg::*;
#(
    parameter int BEEP_TICKS = 3,
    parameter int QUICK_TENS = 3
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       tick_1hz,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       zero_units,
    input  logic       zero_tens,
    input  logic       zero_min,
    output logic [3:0] data_units,
    output logic [3:0] data_tens,
    output logic [3:0] data_min,
    output logic       load_n,
    output logic       count_en,
    output logic       cnt_clrn,
    output logic       heat_on,
    output logic       beep,
    output logic       done,
    output logic [2:0] state
);

    localparam logic [3:0] BEEP_LAST = 4'(BEEP_TICKS - 1);

    state_e     state_q, state_d;
    logic [3:0] beep_cnt_q, beep_cnt_d;
    logic       load_n_q, count_en_q, cnt_clrn_q, heat_on_q, beep_q, done_q;

    logic       entry_clr, entry_shift, entry_quick, clear_cnt;
    logic       key_ok, all_zero, entry_zero;

    timer_entry_reg #(
        .QUICK_TENS (4'(QUICK_TENS))
    ) u_entry (
        .clk     (clk),
        .clrn    (clrn),
        .clr_i   (entry_clr),
        .shift_i (entry_shift),
        .key_i   (key_digit),
        .quick_i (entry_quick),
        .min_o   (data_min),
        .tens_o  (data_tens),
        .units_o (data_units)
    );

    assign key_ok     = key_valid && key_accepted(key_digit);
    assign all_zero   = zero_units && zero_tens && zero_min;
    assign entry_zero = (data_min == 4'd0) && (data_tens == 4'd0) && (data_units == 4'd0);

    // Event priority inside every state: stop, then start, then key.
    always_comb begin
        state_d     = state_q;
        beep_cnt_d  = beep_cnt_q;
        entry_clr   = 1'b0;
        entry_shift = 1'b0;
        entry_quick = 1'b0;
        clear_cnt   = 1'b0;

        case (state_q)
            ST_IDLE, ST_ENTRY: begin
                if (stop) begin
                    entry_clr = 1'b1;
                    clear_cnt = 1'b1;
                    state_d   = ST_IDLE;
                end else if (start) begin
                    if (door_closed) begin
                        entry_quick = entry_zero;
                        state_d     = ST_LOAD;
                    end
                end else if (key_ok) begin
                    entry_shift = 1'b1;
                    state_d     = ST_ENTRY;
                end
            end

            ST_LOAD: state_d = ST_RUN;

            ST_RUN: begin
                if (stop || !door_closed) begin
                    state_d = ST_PAUSE;
                end else if (all_zero) begin
                    state_d = ST_FINISH;
                end
            end

            ST_PAUSE: begin
                if (stop) begin
                    entry_clr = 1'b1;
                    clear_cnt = 1'b1;
                    state_d   = ST_IDLE;
                end else if (start && door_closed) begin
                    state_d = ST_RUN;
                end
            end

            ST_FINISH: begin
                if (stop) begin
                    entry_clr = 1'b1;
                    state_d   = ST_IDLE;
                end else if (tick_1hz) begin
                    if (beep_cnt_q == BEEP_LAST) begin
                        entry_clr = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        beep_cnt_d = beep_cnt_q + 4'd1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // The beep counter restarts from zero on every entry into FINISH.
        if (state_d != ST_FINISH) begin
            beep_cnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= ST_IDLE;
            beep_cnt_q <= 4'd0;
            load_n_q   <= 1'b1;
            count_en_q <= 1'b0;
            cnt_clrn_q <= 1'b1;
            heat_on_q  <= 1'b0;
            beep_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beep_cnt_q <= beep_cnt_d;
            load_n_q   <= (state_d != ST_LOAD);
            count_en_q <= (state_q == ST_RUN) && (state_d == ST_RUN) && tick_1hz && !all_zero;
            cnt_clrn_q <= !clear_cnt;
            heat_on_q  <= (state_d == ST_RUN);
            beep_q     <= (state_d == ST_FINISH);
            done_q     <= (state_d == ST_FINISH) && (state_q != ST_FINISH);
        end
    end

    assign load_n   = load_n_q;
    assign count_en = count_en_q;
    assign cnt_clrn = cnt_clrn_q;
    assign heat_on  = heat_on_q;
    assign beep     = beep_q;
    assign done     = done_q;
    assign state    = state_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Bench for microwave_timer_ctrl: a behavioural BCD down-counter chain closes
// the loop; a vector table covers entry handling, hand sequences the cook flow.
module tb_microwave_timer_ctrl;
    import timer_pkg::*;

    typedef struct packed {
        logic       kv;
        logic [3:0] kd;
        logic       st;
        logic       sp;
        logic       door;
        logic       tick;
    } stim_t;

    typedef struct packed {
        logic [2:0]  st;
        logic [11:0] data;
        logic        load_n;
        logic        count_en;
        logic        cnt_clrn;
        logic        heat_on;
        logic        beep;
        logic        done;
    } outs_t;

    typedef struct {
        stim_t s;
        outs_t e;
    } vec_t;

    localparam int NV = 19;

    logic       clk, clrn;
    logic       tick_1hz, key_valid, start, stop, door_closed;
    logic [3:0] key_digit;
    logic       zero_units, zero_tens, zero_min;
    logic [3:0] data_units, data_tens, data_min;
    logic       load_n, count_en, cnt_clrn, heat_on, beep, done;
    logic [2:0] state;

    logic [3:0] c_u, c_t, c_m;
    outs_t      act;
    logic [20:0] exp_q[$];
    vec_t       vecs[NV];

    int checks = 0;
    int errors = 0;
    int en_seen, done_seen, load_seen, heat_low;

    microwave_timer_ctrl #(
        .BEEP_TICKS (3),
        .QUICK_TENS (3)
    ) dut (
        .clk         (clk),
        .clrn        (clrn),
        .tick_1hz    (tick_1hz),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .start       (start),
        .stop        (stop),
        .door_closed (door_closed),
        .zero_units  (zero_units),
        .zero_tens   (zero_tens),
        .zero_min    (zero_min),
        .data_units  (data_units),
        .data_tens   (data_tens),
        .data_min    (data_min),
        .load_n      (load_n),
        .count_en    (count_en),
        .cnt_clrn    (cnt_clrn),
        .heat_on     (heat_on),
        .beep        (beep),
        .done        (done),
        .state       (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- counter chain model ----------------
    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            c_u <= 4'd0; c_t <= 4'd0; c_m <= 4'd0;
        end else if (!cnt_clrn) begin
            c_u <= 4'd0; c_t <= 4'd0; c_m <= 4'd0;
        end else if (!load_n) begin
            c_u <= data_units; c_t <= data_tens; c_m <= data_min;
        end else if (count_en) begin
            if (c_u != 4'd0) begin
                c_u <= c_u - 4'd1;
            end else begin
                c_u <= MAX_UNITS;
                if (c_t != 4'd0) begin
                    c_t <= c_t - 4'd1;
                end else begin
                    c_t <= MAX_TENS;
                    c_m <= (c_m != 4'd0) ? c_m - 4'd1 : MAX_MIN;
                end
            end
        end
    end

    assign zero_units = (c_u == 4'd0);
    assign zero_tens  = (c_t == 4'd0);
    assign zero_min   = (c_m == 4'd0);

    assign act = {state, data_min, data_tens, data_units, load_n, count_en, cnt_clrn, heat_on, beep, done};

    // ---------------- helpers ----------------
    function automatic stim_t mk(logic kv, logic [3:0] kd, logic st, logic sp, logic dr, logic tk);
        stim_t s;
        s.kv = kv; s.kd = kd; s.st = st; s.sp = sp; s.door = dr; s.tick = tk;
        return s;
    endfunction

    function automatic stim_t s_idle();           return mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0); endfunction
    function automatic stim_t s_key(logic [3:0] d); return mk(1'b1, d, 1'b0, 1'b0, 1'b1, 1'b0); endfunction
    function automatic stim_t s_start();          return mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0); endfunction
    function automatic stim_t s_stop();           return mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0); endfunction
    function automatic stim_t s_tick();           return mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1); endfunction

    function automatic outs_t o(logic [2:0] st, logic [11:0] d, logic ln, logic ce, logic cc,
                                logic h, logic b, logic dn);
        outs_t r;
        r.st = st; r.data = d; r.load_n = ln; r.count_en = ce; r.cnt_clrn = cc;
        r.heat_on = h; r.beep = b; r.done = dn;
        return r;
    endfunction

    // ---------------- driver ----------------
    task automatic do_cycle(input stim_t s);
        @(negedge clk);
        key_valid   = s.kv;
        key_digit   = s.kd;
        start       = s.st;
        stop        = s.sp;
        door_closed = s.door;
        tick_1hz    = s.tick;
        @(posedge clk);
        #1;
        if (count_en) en_seen++;
        if (done)     done_seen++;
        if (!load_n)  load_seen++;
        if (!heat_on) heat_low++;
    endtask

    task automatic clear_stats();
        en_seen = 0; done_seen = 0; load_seen = 0; heat_low = 0;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do_cycle(s_tick());
            do_cycle(s_idle());
        end
    endtask

    // ---------------- scoreboard / checks ----------------
    task automatic apply_vec(input int idx, input stim_t s, input outs_t e);
        logic [20:0] x;
        exp_q.push_back(e);
        do_cycle(s);
        x = exp_q.pop_front();
        checks++;
        if (act !== x) begin
            errors++;
            $display("FAIL vec%0d: got %h expected %h (state,data,load_n,count_en,cnt_clrn,heat,beep,done)",
                     idx, act, x);
        end
    endtask

    task automatic chk1(input string name, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, a, e);
        end
    endtask

    task automatic chkn(input string name, input logic [11:0] a, input logic [11:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    task automatic chki(input string name, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, a, e);
        end
    endtask

    // ---------------- test ----------------
    initial begin
        vecs[0]  = '{s: s_key(4'd9),  e: o(3'd1, 12'h009, 1, 0, 1, 0, 0, 0)};
        vecs[1]  = '{s: s_key(4'd9),  e: o(3'd1, 12'h059, 1, 0, 1, 0, 0, 0)};
        vecs[2]  = '{s: s_key(4'd12), e: o(3'd1, 12'h059, 1, 0, 1, 0, 0, 0)};
        vecs[3]  = '{s: s_key(4'd4),  e: o(3'd1, 12'h554, 1, 0, 1, 0, 0, 0)};
        vecs[4]  = '{s: mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0), e: o(3'd1, 12'h554, 1, 0, 1, 0, 0, 0)};
        vecs[5]  = '{s: mk(1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0), e: o(3'd0, 12'h000, 1, 0, 0, 0, 0, 0)};
        vecs[6]  = '{s: s_idle(),     e: o(3'd0, 12'h000, 1, 0, 1, 0, 0, 0)};
        vecs[7]  = '{s: s_key(4'd7),  e: o(3'd1, 12'h007, 1, 0, 1, 0, 0, 0)};
        vecs[8]  = '{s: s_stop(),     e: o(3'd0, 12'h000, 1, 0, 0, 0, 0, 0)};
        vecs[9]  = '{s: mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0), e: o(3'd0, 12'h000, 1, 0, 1, 0, 0, 0)};
        vecs[10] = '{s: s_key(4'd0),  e: o(3'd1, 12'h000, 1, 0, 1, 0, 0, 0)};
        vecs[11] = '{s: s_key(4'd2),  e: o(3'd1, 12'h002, 1, 0, 1, 0, 0, 0)};
        vecs[12] = '{s: mk(1'b1, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0), e: o(3'd2, 12'h002, 0, 0, 1, 0, 0, 0)};
        vecs[13] = '{s: s_idle(),     e: o(3'd3, 12'h002, 1, 0, 1, 1, 0, 0)};
        vecs[14] = '{s: s_start(),    e: o(3'd3, 12'h002, 1, 0, 1, 1, 0, 0)};
        vecs[15] = '{s: s_stop(),     e: o(3'd4, 12'h002, 1, 0, 1, 0, 0, 0)};
        vecs[16] = '{s: mk(1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0), e: o(3'd4, 12'h002, 1, 0, 1, 0, 0, 0)};
        vecs[17] = '{s: s_stop(),     e: o(3'd0, 12'h000, 1, 0, 0, 0, 0, 0)};
        vecs[18] = '{s: s_idle(),     e: o(3'd0, 12'h000, 1, 0, 1, 0, 0, 0)};

        key_valid = 1'b0; key_digit = 4'd0; start = 1'b0; stop = 1'b0;
        door_closed = 1'b1; tick_1hz = 1'b0;
        clrn = 1'b0;
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        chkn("reset_outputs", 12'(act), 12'(o(3'd0, 12'h000, 1, 0, 1, 0, 0, 0)));
        chkn("reset_data", {data_min, data_tens, data_units}, 12'h000);
        @(negedge clk);
        clrn = 1'b1;

        // Entry, priority and load/pause/stop vectors.
        for (int i = 0; i < NV; i++) begin
            apply_vec(i, vecs[i].s, vecs[i].e);
        end
        chkn("model_cleared", {c_m, c_t, c_u}, 12'h000);

        // 1:30 cook to completion with a 3-tick beep.
        do_cycle(s_key(4'd1));
        do_cycle(s_key(4'd3));
        do_cycle(s_key(4'd0));
        chkn("entry_130", {data_min, data_tens, data_units}, 12'h130);
        do_cycle(s_start());
        chkn("load_state", 12'(state), 12'(ST_LOAD));
        chk1("load_n_low", load_n, 1'b0);
        do_cycle(s_idle());
        chkn("run_state", 12'(state), 12'(ST_RUN));
        chk1("load_n_one_clk", load_n, 1'b1);
        chk1("heat_on_run", heat_on, 1'b1);
        chkn("counters_loaded", {c_m, c_t, c_u}, 12'h130);
        clear_stats();
        run_ticks(90);
        chki("count_en_pulses", en_seen, 90);
        chki("heat_held", heat_low, 0);
        chki("no_early_done", done_seen, 0);
        chkn("counters_zero", {c_m, c_t, c_u}, 12'h000);
        do_cycle(s_idle());
        chkn("finish_state", 12'(state), 12'(ST_FINISH));
        chk1("done_pulse", done, 1'b1);
        chk1("beep_on", beep, 1'b1);
        chk1("heat_off_finish", heat_on, 1'b0);
        do_cycle(s_idle());
        chk1("done_one_clk", done, 1'b0);
        do_cycle(s_key(4'd4));
        do_cycle(s_tick());
        chk1("beep_after_1", beep, 1'b1);
        do_cycle(s_start());
        do_cycle(s_tick());
        chk1("beep_after_2", beep, 1'b1);
        chkn("finish_hold", 12'(state), 12'(ST_FINISH));
        do_cycle(s_tick());
        chk1("beep_after_3", beep, 1'b0);
        chkn("idle_after_beep", 12'(state), 12'(ST_IDLE));
        chkn("entry_cleared", {data_min, data_tens, data_units}, 12'h000);
        chki("done_once", done_seen, 1);

        // Door opened at 0:45, then resumed without reload.
        do_cycle(s_key(4'd5));
        do_cycle(s_key(4'd0));
        do_cycle(s_start());
        do_cycle(s_idle());
        run_ticks(5);
        chkn("at_045", {c_m, c_t, c_u}, 12'h045);
        do_cycle(mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        chkn("pause_state", 12'(state), 12'(ST_PAUSE));
        chk1("pause_heat_off", heat_on, 1'b0);
        clear_stats();
        for (int i = 0; i < 2; i++) begin
            do_cycle(mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
            do_cycle(mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        do_cycle(mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        chkn("start_door_open", 12'(state), 12'(ST_PAUSE));
        chki("pause_no_count", en_seen, 0);
        chkn("pause_hold", {c_m, c_t, c_u}, 12'h045);
        do_cycle(s_start());
        chkn("resume_state", 12'(state), 12'(ST_RUN));
        chk1("resume_heat", heat_on, 1'b1);
        run_ticks(1);
        chkn("resume_044", {c_m, c_t, c_u}, 12'h044);
        chki("resume_no_load", load_seen, 0);
        do_cycle(s_stop());
        do_cycle(s_stop());
        chkn("pause_stop_idle", 12'(state), 12'(ST_IDLE));
        chk1("pause_stop_clr", cnt_clrn, 1'b0);
        do_cycle(s_idle());
        chkn("pause_stop_counters", {c_m, c_t, c_u}, 12'h000);

        // Quick start with an empty entry, then stop during the beep.
        do_cycle(s_start());
        chkn("quick_data", {data_min, data_tens, data_units}, 12'h030);
        do_cycle(s_idle());
        clear_stats();
        run_ticks(30);
        chki("quick_pulses", en_seen, 30);
        do_cycle(s_idle());
        chk1("quick_done", done, 1'b1);
        do_cycle(s_stop());
        chkn("stop_finish_idle", 12'(state), 12'(ST_IDLE));
        chk1("stop_finish_beep", beep, 1'b0);

        // stop wins over 0:00 in the same cycle.
        do_cycle(s_key(4'd1));
        do_cycle(s_start());
        do_cycle(s_idle());
        clear_stats();
        run_ticks(1);
        do_cycle(s_stop());
        chkn("stop_vs_zero", 12'(state), 12'(ST_PAUSE));
        chki("stop_vs_zero_done", done_seen, 0);
        do_cycle(s_stop());

        // Asynchronous reset mid-cook.
        do_cycle(s_key(4'd2));
        do_cycle(s_start());
        do_cycle(s_idle());
        run_ticks(1);
        chk1("pre_reset_heat", heat_on, 1'b1);
        @(negedge clk);
        #2 clrn = 1'b0;
        #1;
        chk1("async_heat_off", heat_on, 1'b0);
        chkn("async_state", 12'(state), 12'(ST_IDLE));
        chkn("async_entry", {data_min, data_tens, data_units}, 12'h000);
        @(negedge clk);
        clrn = 1'b1;
        do_cycle(s_idle());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/microwave_timer_ctrl.md
Name: microwave_timer_ctrl

Overview:
- Sequencer for the microwave cook timer: a chain of three BCD down counters (minutes mod-10, seconds-tens mod-6, seconds-units mod-10).
- Collects keypad digits into an M:ST entry register, then drives the counters' parallel load, count enable and clear.
- Detects 0:00, drives the magnetron enable, and runs the end-of-cook beep.
- Sits between the keypad/button debouncers and the counter chain; the counters cascade among themselves via their tc outputs.

Parameters:
- BEEP_TICKS, 3, number of tick_1hz periods the beep output stays high after completion (1..15).
- QUICK_TENS, 3, seconds-tens digit loaded by quick start (start with an empty entry gives 0:QUICK_TENS0).

Ports:
- clk  in  1  system clock
- clrn  in  1  reset; asynchronous, active-low
- tick_1hz  in  1  one-clk-wide pulse once per second
- key_valid  in  1  one-clk pulse; key_digit is valid
- key_digit  in  4  BCD digit; values >9 are ignored
- start  in  1  one-clk pulse, start/resume
- stop  in  1  one-clk pulse, pause/cancel
- door_closed  in  1  level, 1 = door shut
- zero_units, zero_tens, zero_min  in  1 each  zero flags from the counters
- data_units, data_tens, data_min  out  4 each  parallel-load data to the counters
- load_n  out  1  active-low counter load, one clk wide
- count_en  out  1  enable to the seconds-units counter
- cnt_clrn  out  1  registered active-low counter clear, one clk wide
- heat_on  out  1  magnetron enable
- beep  out  1  buzzer enable
- done  out  1  one-clk pulse at completion
- state  out  3  current FSM state encoding, for display/debug

Behaviour:
- Reset (clrn=0), asynchronous:
  - state IDLE; entry register 0:00; data_* = 0.
  - load_n=1, cnt_clrn=1, count_en=0, heat_on=0, beep=0, done=0.
- States:
  - IDLE=0, ENTRY=1, LOAD=2, RUN=3, PAUSE=4, FINISH=5.
  - Unused encodings go to IDLE on the next clk.
- Input priority when pulses coincide in one cycle: stop > start > key_valid. Lower-priority events that cycle are dropped.
- Entry register (min, tens, units):
  - Valid key in IDLE or ENTRY shifts left: min<=tens, tens<=units, units<=key.
  - Overflow of the old min digit is discarded.
  - If the old units digit is >5, tens saturates to 5.
  - A key in IDLE moves the FSM to ENTRY.
- data_* always mirror the entry register.
- stop in IDLE or ENTRY: clear entry to 0:00, pulse cnt_clrn low for 1 clk, go to IDLE.
- start in IDLE or ENTRY with door_closed=1:
  - If entry is 0:00, first load QUICK_TENS into the tens digit (same cycle).
  - Go to LOAD.
  - start with the door open is ignored.
- LOAD: load_n=0 for exactly one clk, then RUN. Counters sample data_* on that edge.
- RUN:
  - heat_on=1.
  - count_en = tick_1hz & ~all_zero, where all_zero = zero_units & zero_tens & zero_min.
  - all_zero=1 goes to FINISH. This is checked the clk after LOAD, so a just-loaded nonzero value never finishes early.
  - Counters therefore never wrap past 0:00.
  - door_closed=0 or stop goes to PAUSE; heat_on drops the next clk.
  - stop and all_zero in the same cycle: stop wins.
- PAUSE:
  - heat_on=0, count_en=0; counter contents are held.
  - start with door closed goes to RUN with no reload.
  - stop clears counters via cnt_clrn, clears entry, goes to IDLE.
- FINISH:
  - done=1 on the first clk only.
  - beep=1; a 4-bit beep counter counts tick_1hz.
  - After BEEP_TICKS ticks: beep=0, entry cleared, go to IDLE.
  - stop in FINISH ends the beep immediately, then IDLE.
  - Keys and start are ignored in FINISH.
- All outputs are registered (Moore). Latency from any input pulse to its output effect is 1 clk.
- clrn asserted mid-cook: immediate return to reset values; heat_on drops asynchronously.

Decomposition:
- Shared package timer_pkg holds:
  - state encodings;
  - BCD limits (MAX_UNITS=9, MAX_TENS=5, MAX_MIN=9);
  - the key-ignore threshold.
- One natural sub-module: timer_entry_reg, the shift/saturate digit register with clear. The FSM stays in the top module.

Test Plan:
- Keys 1,3,0 then start, door closed -> data=1:30; load_n low one clk; heat_on=1; count_en pulses on ticks; after 90 ticks done pulses once, beep high 3 ticks, then IDLE.
- Keys 9,9 -> tens saturates: entry 0:99 shifts as units=9, then 9 into tens as 5 -> data 0:59; key 12 ignored.
- Start with empty entry -> loads 0:30, runs 30 ticks, finishes.
- Door opened at 0:45 -> PAUSE, heat_on=0, counters hold 0:45; door closed + start -> RUN, resumes 0:44 on next tick with no load_n pulse.
- stop and start in the same clk during ENTRY -> entry cleared, cnt_clrn pulse, IDLE; start dropped.
- clrn pulsed low mid-RUN -> heat_on=0 immediately, state IDLE, entry 0:00.
